rr_pckt_allocator: RTL and testbench

Parametrised output-port allocator for the symmetric butterfly switch, one instance per router output port. It arbitrates packet headers from all input channels using two-class priority with round-robin fairness inside each class. It holds the output for the winning input until that input stops presenting payload flits. A per-input wait counter promotes long-waiting requesters, so no input can be starved.

---
 rtl/rr_pckt_allocator.sv | 139 +++++++++++++
 tb/tb_rr_pckt_allocator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_pckt_allocator.sv
// ============================================================================
// Module   : rr_pckt_allocator
// Brief    : Output-port allocator with two-class round-robin arbitration,
//            packet hold, and wait-counter promotion against starvation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pckt_allocator #(
    parameter int PORTS    = 4,
    parameter int ADR_W    = $clog2(PORTS),
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADR_W-1:0]              r_adr,
    input  logic [PORTS*(ADR_W+2)-1:0]    in_ch_hdr_msn,
    input  logic [PORTS-1:0]              priority_field,
    output logic [PORTS-1:0]              sel,
    output logic                          shift,
    output logic                          busy,
    output logic [ADR_W-1:0]              owner
);

    localparam int                FW      = ADR_W + 2;
    localparam logic [ADR_W:0]    C_PORTS = (ADR_W + 1)'(PORTS);
    localparam logic [PORTS-1:0]  C_ONE   = PORTS'(1);
    localparam logic [WAIT_W-1:0] C_MAXW  = WAIT_W'(MAX_WAIT);
    localparam logic [1:0]        C_HDR   = 2'b11;
    localparam logic [1:0]        C_PAY   = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADR_W-1:0]   r_owner;
    logic [ADR_W-1:0]   r_rr_ptr;
    logic [WAIT_W-1:0]  r_wait [PORTS];

    logic [1:0]         w_type [PORTS];
    logic [PORTS-1:0]   w_req;
    logic [PORTS-1:0]   w_starved;
    logic [PORTS-1:0]   w_urgent;
    logic [PORTS-1:0]   w_cand;
    logic [PORTS-1:0]   w_gnt;
    logic               w_hold;
    logic               w_arb_vld;
    logic [ADR_W-1:0]   w_arb_idx;
    logic [ADR_W:0]     w_sum;
    logic [ADR_W-1:0]   w_idx;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_ch
            assign w_type[gi]    = in_ch_hdr_msn[gi*FW+ADR_W +: 2];
            assign w_req[gi]     = (w_type[gi] == C_HDR) &&
                                   (in_ch_hdr_msn[gi*FW +: ADR_W] == r_adr);
            assign w_starved[gi] = (r_wait[gi] == C_MAXW);
        end
    endgenerate

    assign w_urgent = w_req & (priority_field | w_starved);
    assign w_cand   = (|w_urgent) ? w_urgent : w_req;

    // Owner keeps the port only while it streams payload; anything else ends the packet.
    assign w_hold = (r_state == S_BUSY) && (w_type[r_owner] == C_PAY);

    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < PORTS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + k[ADR_W:0];
            if (w_sum >= C_PORTS) begin
                w_sum = w_sum - C_PORTS;
            end
            w_idx = w_sum[ADR_W-1:0];
            if (!w_arb_vld && w_cand[w_idx]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;
        if (!w_hold && w_arb_vld) begin
            w_gnt = C_ONE << w_arb_idx;
        end
        if (|w_gnt) begin
            w_state_nxt = S_BUSY;
        end else if (!w_hold) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign sel   = !rst_n ? '0 : (w_hold ? (C_ONE << r_owner) : w_gnt);
    assign shift = rst_n && (|w_gnt);
    assign busy  = (r_state == S_BUSY);
    assign owner = r_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (|w_gnt) begin
                r_owner  <= w_arb_idx;
                r_rr_ptr <= ({1'b0, w_arb_idx} == C_PORTS - 1'b1) ? '0 : w_arb_idx + 1'b1;
            end
        end
    end

    generate
        for (genvar gw = 0; gw < PORTS; gw++) begin : g_wait
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wait[gw] <= '0;
                end else if (w_req[gw] && !w_gnt[gw]) begin
                    if (!w_starved[gw]) begin
                        r_wait[gw] <= r_wait[gw] + 1'b1;
                    end
                end else begin
                    r_wait[gw] <= '0;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rr_pckt_allocator.sv
// ============================================================================
// Module   : tb_rr_pckt_allocator
// Brief    : Bench for rr_pckt_allocator: vector table, directed corner cases
//            and random traffic against a reference model (MAX_WAIT 15 and 3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_pckt_allocator;

    localparam logic [3:0] H = 4'b1110;   // header to port 2
    localparam logic [3:0] P = 4'b1010;   // payload
    localparam logic [3:0] N = 4'b0000;   // null

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  radr = 2'd2;
    logic [15:0] hdr = '0;
    logic [3:0]  pri = '0;

    logic [3:0]  sel0, sel1;
    logic        shift0, shift1, busy0, busy1;
    logic [1:0]  owner0, owner1;

    int n_checks = 0;
    int n_fail   = 0;

    rr_pckt_allocator #(.PORTS(4), .MAX_WAIT(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .r_adr(radr), .in_ch_hdr_msn(hdr),
        .priority_field(pri), .sel(sel0), .shift(shift0), .busy(busy0), .owner(owner0));

    rr_pckt_allocator #(.PORTS(4), .MAX_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .r_adr(radr), .in_ch_hdr_msn(hdr),
        .priority_field(pri), .sel(sel1), .shift(shift1), .busy(busy1), .owner(owner1));

    always #5 clk = ~clk;

    // Reference model state, one set per instance
    int   maxw [2] = '{15, 3};
    bit   mb [2];
    int   mo [2], mp [2];
    int   mw [2][4];
    bit   nb [2];
    int   no [2], np [2];
    int   nw [2][4];
    logic [3:0] e_sel [2];
    bit   e_shift [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mb[m] = 0; mo[m] = 0; mp[m] = 0;
            nb[m] = 0; no[m] = 0; np[m] = 0;
            for (int i = 0; i < 4; i++) begin
                mw[m][i] = 0; nw[m][i] = 0;
            end
        end
    endtask

    task automatic model_eval(input int m);
        logic [3:0] f;
        int  typ [4];
        bit  rq [4];
        bit  urg [4];
        bit  anyu, hold;
        int  win, j;
        anyu = 0;
        win  = -1;
        for (int i = 0; i < 4; i++) begin
            f      = hdr[i*4 +: 4];
            typ[i] = int'(f[3:2]);
            rq[i]  = (f[3:2] == 2'b11) && (f[1:0] == radr);
            urg[i] = rq[i] && (pri[i] || mw[m][i] == maxw[m]);
            if (urg[i]) anyu = 1;
        end
        hold = mb[m] && (typ[mo[m]] == 2);
        if (!hold) begin
            for (int k = 0; k < 4; k++) begin
                j = (mp[m] + k) % 4;
                if (win < 0 && (anyu ? urg[j] : rq[j])) win = j;
            end
        end
        if (hold)          e_sel[m] = 4'b0001 << mo[m];
        else if (win >= 0) e_sel[m] = 4'b0001 << win;
        else               e_sel[m] = 4'b0000;
        e_shift[m] = (win >= 0);
        nb[m] = mb[m]; no[m] = mo[m]; np[m] = mp[m];
        if (win >= 0) begin
            nb[m] = 1; no[m] = win; np[m] = (win + 1) % 4;
        end else if (!hold) begin
            nb[m] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rq[i] && i != win) nw[m][i] = (mw[m][i] >= maxw[m]) ? maxw[m] : mw[m][i] + 1;
            else                   nw[m][i] = 0;
        end
        if (!rst_n) begin
            e_sel[m] = '0; e_shift[m] = 0;
            nb[m] = 0; no[m] = 0; np[m] = 0;
            for (int i = 0; i < 4; i++) nw[m][i] = 0;
        end
    endtask

    // Apply inputs mid-cycle and compare combinational outputs with the model
    task automatic drive(input logic [15:0] h, input logic [3:0] p);
        hdr = h;
        pri = p;
        #2;
        model_eval(0);
        model_eval(1);
        chk("sel",        32'(sel0),   32'(e_sel[0]));
        chk("shift",      32'(shift0), 32'(e_shift[0]));
        chk("sel_mw3",    32'(sel1),   32'(e_sel[1]));
        chk("shift_mw3",  32'(shift1), 32'(e_shift[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            mb[m] = nb[m]; mo[m] = no[m]; mp[m] = np[m];
            for (int i = 0; i < 4; i++) mw[m][i] = nw[m][i];
        end
        #1;
        chk("busy",     32'(busy0), 32'(mb[0]));
        chk("busy_mw3", 32'(busy1), 32'(mb[1]));
        if (mb[0]) chk("owner",     32'(owner0), 32'(mo[0]));
        if (mb[1]) chk("owner_mw3", 32'(owner1), 32'(mo[1]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        drive(16'h0000, 4'h0);
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] hdr;
        logic [3:0]  pri;
        logic [3:0]  sel;
        logic        shift;
        int          own;
    } vec_t;

    vec_t tbl [13];
    logic [3:0] seq3 [4];
    logic [3:0] seq15 [4];

    initial begin
        // Round-robin table: packets of header + 2 payload, grant order 0,1,2,3,0
        for (int k = 0; k < 13; k++) begin
            int c, pos;
            c   = (k / 3) % 4;
            pos = k % 3;
            for (int i = 0; i < 4; i++) begin
                tbl[k].hdr[i*4 +: 4] = (i == c && pos != 0) ? P : H;
            end
            tbl[k].pri   = 4'h0;
            tbl[k].sel   = 4'b0001 << c;
            tbl[k].shift = (pos == 0);
            tbl[k].own   = c;
        end

        // Reset defaults
        rst_n = 1'b0;
        model_reset();
        #3;
        drive({H, H, H, H}, 4'h0);
        chk("rst_sel",   32'(sel0),   32'h0);
        chk("rst_shift", 32'(shift0), 32'h0);
        tick();
        chk("rst_busy",  32'(busy0),  32'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].hdr, tbl[k].pri);
            chk("rr_sel",   32'(sel0),   32'(tbl[k].sel));
            chk("rr_shift", 32'(shift0), 32'(tbl[k].shift));
            tick();
            chk("rr_busy",  32'(busy0),  32'h1);
            chk("rr_owner", 32'(owner0), 32'(tbl[k].own));
        end

        // Priority class beats round-robin order
        do_reset();
        drive({H, N, H, H}, 4'b1000);
        chk("pri_sel", 32'(sel0), 32'b1000);
        tick();
        drive({H, N, H, H}, 4'b0000);
        chk("pri_next_sel", 32'(sel0), 32'b0001);
        tick();

        // Hold and payload isolation
        do_reset();
        drive({N, H, N, N}, 4'h0);
        chk("hold_gnt", 32'(sel0), 32'b0100);
        tick();
        drive({H, P, P, N}, 4'h0);
        chk("hold_sel",   32'(sel0),   32'b0100);
        chk("hold_shift", 32'(shift0), 32'h0);
        tick();
        drive({H, N, P, N}, 4'h0);
        chk("release_sel",   32'(sel0),   32'b1000);
        chk("release_shift", 32'(shift0), 32'h1);
        tick();

        // Starvation promotion: ch0/ch2 high priority back-to-back, ch1 low
        seq3  = '{4'b0001, 4'b0100, 4'b0001, 4'b0010};
        seq15 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive({N, H, H, H}, 4'b0101);
            chk("starve_sel_mw3", 32'(sel1), 32'(seq3[k]));
            chk("starve_sel",     32'(sel0), 32'(seq15[k]));
            tick();
        end

        // Mid-packet reset
        do_reset();
        drive({N, N, H, N}, 4'h0);
        tick();
        chk("mid_busy",  32'(busy0),  32'h1);
        chk("mid_owner", 32'(owner0), 32'h1);
        drive({N, N, P, N}, 4'h0);
        chk("mid_hold", 32'(sel0), 32'b0010);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy", 32'(busy0), 32'h0);
        chk("mid_rst_sel",  32'(sel0),  32'h0);
        drive({N, N, P, N}, 4'h0);
        tick();
        rst_n = 1'b1;
        drive({N, N, P, N}, 4'h0);
        chk("post_rst_sel",   32'(sel0),   32'h0);
        chk("post_rst_shift", 32'(shift0), 32'h0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [15:0] h;
            logic [3:0]  p;
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)      h[i*4 +: 4] = {2'b11, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd2};
                else if (r < 7) h[i*4 +: 4] = {2'b10, 2'($urandom)};
                else if (r < 9) h[i*4 +: 4] = {2'b00, 2'($urandom)};
                else            h[i*4 +: 4] = {2'b01, 2'($urandom)};
                p[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            drive(h, p);
            tick();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
